// File: rtl/i2s_pkg.sv
// Shared constants and FSM encoding for the I2S channel scheduler.
// Default channel layout: 4 stereo receivers, even index = left, odd index = right.
package i2s_pkg;

    localparam int DATA_W = 24;
    localparam int NUM_CH = 8;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } sched_state_t;

endpackage

// File: rtl/i2s_chan_sched_if.sv
// Output word stream of the I2S channel scheduler: valid/ready handshake plus
// the sample, its channel index and an end-of-frame marker.
interface i2s_chan_sched_if #(
    parameter int DATA_W = i2s_pkg::DATA_W,
    parameter int CH_W   = i2s_pkg::CH_W
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_chan;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_chan,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_chan,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/i2s_edge_det.sv
// Word-clock falling-edge detector: registers i2s_wclk and flags the posedge at
// which the registered copy is high while the live word clock is already low.
module i2s_edge_det (
    input  logic i2s_bclk,
    input  logic rst_n,
    input  logic i2s_wclk,
    output logic frame_edge
);

    logic wclk_lat;

    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge value of its inputs, regardless of block ordering.
    always_ff @(posedge i2s_bclk or negedge rst_n) begin
        if (!rst_n) begin
            wclk_lat <= 1'b0;
        end else begin
            wclk_lat <= i2s_wclk;
        end
    end

    assign frame_edge = wclk_lat & ~i2s_wclk;

endmodule

// File: rtl/i2s_chan_sched.sv
// I2S channel scheduler: snapshots all receiver words on a frame edge and streams
// the enabled channels out in index order. Optional feature: I2S_SCHED_SKIP_EN.
module i2s_chan_sched #(
    parameter int DATA_W = i2s_pkg::DATA_W,
    parameter int NUM_CH = i2s_pkg::NUM_CH,
    parameter int CH_W   = i2s_pkg::CH_W
) (
    input  logic                     i2s_bclk,
    input  logic                     rst_n,
    input  logic                     i2s_wclk,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_detect,
    i2s_chan_sched_if.master         out_if,
    output logic                     overrun,
    output logic [7:0]               overrun_cnt,
    input  logic                     overrun_clr
);

    import i2s_pkg::*;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              frame_edge;
    logic              ovr_evt;
    logic              at_end;
    logic              higher_set;
    logic [CH_W-1:0]   ptr;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mask_in;
    logic [DATA_W-1:0] snap [NUM_CH];

    i2s_edge_det u_edge_det (
        .i2s_bclk   (i2s_bclk),
        .rst_n      (rst_n),
        .i2s_wclk   (i2s_wclk),
        .frame_edge (frame_edge)
    );

`ifdef I2S_SCHED_SKIP_EN
    assign mask_in = ch_detect;
`else
    // Every channel is sent each frame; the detect flags have no effect.
    logic unused_detect;
    assign unused_detect = ^ch_detect;
    assign mask_in       = '1;
`endif

    assign at_end  = (ptr == CH_W'(NUM_CH - 1));
    assign ovr_evt = frame_edge && (state != IDLE);

    // out_last looks ahead in the mask rather than at what is actually sent later.
    // NOTE: combinational outputs get a default before any branch so no path
    // leaves them unassigned, which would otherwise infer a latch.
    always_comb begin
        higher_set = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i > int'(ptr) && mask[i]) begin
                higher_set = 1'b1;
            end
        end
    end

    always_ff @(posedge i2s_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_edge) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (mask[ptr]) begin
                    state_nxt = SEND;
                end else if (at_end) begin
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (out_if.out_ready) begin
                    state_nxt = at_end ? IDLE : SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_if.out_valid = (state == SEND);

    // NOTE: the snapshot array carries a defined reset value, so it sits in the
    // reset branch like ordinary registers instead of being left uninitialised.
    always_ff @(posedge i2s_bclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= '0;
            mask            <= '0;
            out_if.out_data <= '0;
            out_if.out_chan <= '0;
            out_if.out_last <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_edge) begin
                        ptr  <= '0;
                        mask <= mask_in;
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap[k] <= ch_data[k*DATA_W +: DATA_W];
                        end
                    end
                end
                SCAN: begin
                    if (mask[ptr]) begin
                        out_if.out_data <= snap[ptr];
                        out_if.out_chan <= ptr;
                        out_if.out_last <= ~higher_set;
                    end else if (!at_end) begin
                        ptr <= ptr + CH_W'(1);
                    end
                end
                SEND: begin
                    if (out_if.out_ready && !at_end) begin
                        ptr <= ptr + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A frame edge while busy is dropped; a simultaneous clear restarts the count at one.
    always_ff @(posedge i2s_bclk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (ovr_evt) begin
            overrun <= 1'b1;
            if (overrun_clr) begin
                overrun_cnt <= 8'd1;
            end else if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (overrun_clr) begin
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_i2s_chan_sched.sv
// Directed self-checking bench for i2s_chan_sched; the skip scenarios follow
// whether I2S_SCHED_SKIP_EN is defined for the build.
module tb_i2s_chan_sched;

    localparam int DW = 24;
    localparam int NC = 8;
    localparam int CW = 3;

    logic             i2s_bclk;
    logic             rst_n;
    logic             i2s_wclk;
    logic [NC*DW-1:0] ch_data;
    logic [NC-1:0]    ch_detect;
    logic             overrun;
    logic [7:0]       overrun_cnt;
    logic             overrun_clr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] obs_data [$];
    logic [CW-1:0] obs_chan [$];
    logic          obs_last [$];
    int            exp_ch [8];

    i2s_chan_sched_if #(.DATA_W(DW), .CH_W(CW)) bus ();

    i2s_chan_sched #(.DATA_W(DW), .NUM_CH(NC), .CH_W(CW)) dut (
        .i2s_bclk    (i2s_bclk),
        .rst_n       (rst_n),
        .i2s_wclk    (i2s_wclk),
        .ch_data     (ch_data),
        .ch_detect   (ch_detect),
        .out_if      (bus),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .overrun_clr (overrun_clr)
    );

    initial i2s_bclk = 1'b0;
    always #5 i2s_bclk = ~i2s_bclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i2s_bclk);
        #1;
    endtask

    task automatic frame_edge();
        i2s_wclk = 1'b0;
        tick();
        i2s_wclk = 1'b1;
    endtask

    task automatic load_data(input logic [DW-1:0] base);
        for (int k = 0; k < NC; k++) begin
            ch_data[k*DW +: DW] = base + DW'(k);
        end
    endtask

    // Rising edges counted from and including the edge posedge until out_valid is seen.
    task automatic measure_latency(input string tag, input int exp_lat);
        int lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic collect(input int stall_ch, input int stall_cycles,
                           input logic [DW-1:0] stall_data, input int budget);
        int stalled = 0;
        bit done    = 1'b0;
        obs_data.delete();
        obs_chan.delete();
        obs_last.delete();
        for (int c = 0; c < budget && !done; c++) begin
            if (stalled > 0 && stalled < stall_cycles) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(stall_data));
                check("hold_chan", 32'(bus.out_chan), stall_ch);
                stalled++;
            end else if (bus.out_valid) begin
                if (stalled == 0 && stall_cycles > 0 && int'(bus.out_chan) == stall_ch) begin
                    check("stall_data", 32'(bus.out_data), 32'(stall_data));
                    bus.out_ready = 1'b0;
                    stalled       = 1;
                end else begin
                    bus.out_ready = 1'b1;
                    obs_data.push_back(bus.out_data);
                    obs_chan.push_back(bus.out_chan);
                    obs_last.push_back(bus.out_last);
                    if (bus.out_last) done = 1'b1;
                end
            end
            tick();
        end
        bus.out_ready = 1'b1;
        check("frame_done", 32'(done), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [DW-1:0] base);
        check({tag, "_count"}, obs_data.size(), n);
        for (int i = 0; i < n && i < obs_data.size(); i++) begin
            check({tag, "_data"}, 32'(obs_data[i]), 32'(base + DW'(exp_ch[i])));
            check({tag, "_chan"}, 32'(obs_chan[i]), exp_ch[i]);
            check({tag, "_last"}, 32'(obs_last[i]), (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        i2s_wclk      = 1'b1;
        bus.out_ready = 1'b1;
        overrun_clr   = 1'b0;
        ch_detect     = 8'hFF;
        load_data(24'h100000);
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_chan", 32'(bus.out_chan), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ovr_cnt", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // All channels, channel k carries 0x100000+k.
        exp_ch = '{0, 1, 2, 3, 4, 5, 6, 7};
        frame_edge();
        check("scan_not_valid", 32'(bus.out_valid), 32'd0);
        measure_latency("lat_ch0", 2);
        collect(-1, 0, '0, 40);
        check_frame("seq", 8, 24'h100000);
        tick();
        tick();
        check("idle_after_frame", 32'(bus.out_valid), 32'd0);

`ifdef I2S_SCHED_SKIP_EN
        ch_detect = 8'b1010_0101;
        exp_ch    = '{0, 2, 5, 7, 0, 0, 0, 0};
        frame_edge();
        measure_latency("lat_skip0", 2);
        collect(-1, 0, '0, 40);
        check_frame("skip", 4, 24'h100000);

        ch_detect = 8'b1111_1000;
        exp_ch    = '{3, 4, 5, 6, 7, 0, 0, 0};
        frame_edge();
        measure_latency("lat_skip3", 5);
        collect(-1, 0, '0, 40);
        check_frame("skip3", 5, 24'h100000);

        // Empty mask: 8 SCAN cycles, an edge on the last one is dropped, the next is taken.
        ch_detect = 8'h00;
        frame_edge();
        for (int i = 0; i < 7; i++) begin
            check("empty_no_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        i2s_wclk = 1'b0;
        tick();
        i2s_wclk = 1'b1;
        check("empty_last_scan_ovr", 32'(overrun_cnt), 32'd1);
        check("empty_no_valid_end", 32'(bus.out_valid), 32'd0);
        tick();
        ch_detect = 8'h01;
        exp_ch    = '{0, 0, 0, 0, 0, 0, 0, 0};
        frame_edge();
        check("empty_idle_edge_ok", 32'(overrun_cnt), 32'd1);
        measure_latency("lat_after_empty", 2);
        collect(-1, 0, '0, 40);
        check_frame("single", 1, 24'h100000);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("empty_ovr_clr", 32'(overrun_cnt), 32'd0);
        ch_detect = 8'hFF;
`else
        ch_detect = 8'b1010_0101;
        frame_edge();
        measure_latency("lat_detect_ignored", 2);
        collect(-1, 0, '0, 40);
        check_frame("ignore", 8, 24'h100000);
        ch_detect = 8'hFF;
`endif

        // Back-pressure for 5 cycles on channel 3.
        exp_ch = '{0, 1, 2, 3, 4, 5, 6, 7};
        load_data(24'hABC000);
        frame_edge();
        collect(3, 5, 24'hABC003, 60);
        check_frame("stall", 8, 24'hABC000);

        // Second edge during SEND is dropped; the snapshot survives input changes.
        load_data(24'h550000);
        bus.out_ready = 1'b0;
        frame_edge();
        load_data(24'h770000);
        tick();
        check("ovr_in_send", 32'(bus.out_valid), 32'd1);
        i2s_wclk = 1'b0;
        tick();
        i2s_wclk = 1'b1;
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_cnt1", 32'(overrun_cnt), 32'd1);
        check("ovr_keep_chan", 32'(bus.out_chan), 32'd0);
        check("ovr_keep_data", 32'(bus.out_data), 32'h550000);
        collect(-1, 0, '0, 40);
        check_frame("ovr_frame", 8, 24'h550000);

        // Saturation at 255, then a clear coinciding with an event.
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("clr_flag", 32'(overrun), 32'd0);
        check("clr_cnt", 32'(overrun_cnt), 32'd0);
        bus.out_ready = 1'b0;
        frame_edge();
        tick();
        for (int i = 0; i < 255; i++) begin
            i2s_wclk = 1'b0;
            tick();
            i2s_wclk = 1'b1;
            tick();
        end
        check("sat_cnt255", 32'(overrun_cnt), 32'd255);
        for (int i = 0; i < 45; i++) begin
            i2s_wclk = 1'b0;
            tick();
            i2s_wclk = 1'b1;
            tick();
        end
        check("sat_cnt300", 32'(overrun_cnt), 32'd255);
        check("sat_flag", 32'(overrun), 32'd1);
        i2s_wclk    = 1'b0;
        overrun_clr = 1'b1;
        tick();
        i2s_wclk    = 1'b1;
        overrun_clr = 1'b0;
        check("clr_evt_flag", 32'(overrun), 32'd1);
        check("clr_evt_cnt", 32'(overrun_cnt), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("clr2_flag", 32'(overrun), 32'd0);
        check("clr2_cnt", 32'(overrun_cnt), 32'd0);
        collect(-1, 0, '0, 40);
        check_frame("sat_frame", 8, 24'h770000);

        // Reset while channel 1 is waiting for a handshake.
        load_data(24'h330000);
        bus.out_ready = 1'b0;
        frame_edge();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_chan", 32'(bus.out_chan), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_chan", 32'(bus.out_chan), 32'd0);
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        load_data(24'h440000);
        frame_edge();
        measure_latency("lat_after_rst", 2);
        collect(-1, 0, '0, 40);
        check_frame("post_rst", 8, 24'h440000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
